alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Memory and ALU bus between the sequencer (master) and its memory/ALU devices (slave).
// All master outputs are registered inside the sequencer.
interface alu_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          alu_en;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_operand;
  logic [DW-1:0] alu_result;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output alu_en, alu_op, alu_operand,
    input  alu_result
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  alu_en, alu_op, alu_operand,
    output alu_result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-byte-instruction accumulator sequencer: fetches opcode/argument, reads or writes
// memory, and strobes an external combinational ALU once per arithmetic instruction.
module alu_sequencer #(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  alu_sequencer_if.master bus,
  output logic [DW-1:0]   acc,
  output logic [AW-1:0]   pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_ARG,
    READ,
    EXEC,
    WRITE,
    HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h8;
  localparam logic [3:0] OP_STA = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t        state, state_nxt;
  logic [3:0]    ir, ir_nxt;
  logic [DW-1:0] arg, arg_nxt;
  logic [DW-1:0] operand, operand_nxt;
  logic [DW-1:0] acc_nxt;
  logic [AW-1:0] pc_nxt;
  logic          illegal_nxt;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  // Next-state and datapath update; only the low opcode nibble is decoded.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    arg_nxt     = arg;
    acc_nxt     = acc;
    operand_nxt = operand;
    illegal_nxt = illegal;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH_OP;
      end
      FETCH_OP: begin
        if (bus.mem_ack) begin
          ir_nxt = bus.mem_rdata[3:0];
          pc_nxt = pc + AW'(1);
          if (bus.mem_rdata[3:0] == OP_HLT) begin
            state_nxt = HALT;
          end else if (is_illegal_op(bus.mem_rdata[3:0])) begin
            state_nxt   = HALT;
            illegal_nxt = 1'b1;
          end else begin
            state_nxt = FETCH_ARG;
          end
        end
      end
      FETCH_ARG: begin
        if (bus.mem_ack) begin
          arg_nxt = bus.mem_rdata;
          pc_nxt  = pc + AW'(1);
          if (ir == OP_JMP) begin
            pc_nxt    = AW'(bus.mem_rdata);
            state_nxt = FETCH_OP;
          end else if (ir == OP_STA) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          if (ir == OP_LDA) begin
            acc_nxt   = bus.mem_rdata;
            state_nxt = FETCH_OP;
          end else begin
            operand_nxt = bus.mem_rdata;
            state_nxt   = EXEC;
          end
        end
      end
      EXEC: begin
        acc_nxt   = bus.alu_result;
        state_nxt = FETCH_OP;
      end
      WRITE: begin
        if (bus.mem_ack) state_nxt = FETCH_OP;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they always match the current state
  // and stay constant while a transfer waits for mem_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      acc             <= '0;
      ir              <= '0;
      arg             <= '0;
      operand         <= '0;
      illegal         <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.alu_en      <= 1'b0;
      bus.alu_op      <= '0;
      bus.alu_operand <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      acc           <= acc_nxt;
      ir            <= ir_nxt;
      arg           <= arg_nxt;
      operand       <= operand_nxt;
      illegal       <= illegal_nxt;
      busy          <= (state_nxt != IDLE) && (state_nxt != HALT);
      halted        <= (state_nxt == HALT);
      bus.mem_req   <= (state_nxt == FETCH_OP) || (state_nxt == FETCH_ARG) ||
                       (state_nxt == READ)     || (state_nxt == WRITE);
      bus.mem_we    <= (state_nxt == WRITE);
      bus.mem_addr  <= ((state_nxt == READ) || (state_nxt == WRITE)) ? AW'(arg_nxt) : pc_nxt;
      bus.mem_wdata <= (state_nxt == WRITE) ? acc_nxt : '0;
      bus.alu_en      <= (state_nxt == EXEC);
      bus.alu_op      <= (state_nxt == EXEC) ? ir_nxt : '0;
      bus.alu_operand <= (state_nxt == EXEC) ? operand_nxt : '0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory with per-transfer wait table, external ALU, and an
// instruction-level reference interpreter for randomized programs.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
  logic          busy, halted, illegal;

  alu_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  alu_sequencer #(.DW(DW), .AW(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .acc(acc), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prog [256];
  logic [7:0] mem  [256];
  logic [7:0] mm   [256];
  int         wait_tab [64];
  logic       tb_clr, force_ack;
  int         wait_cnt, xfer_idx, total_waits, n_alu, alu_viol, stab_viol, cur_wait;
  logic          hold_pend, hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~b;
      4'h6: return a << b[2:0];
      4'h7: return a >> b[2:0];
      default: return a;
    endcase
  endfunction

  assign cur_wait       = (xfer_idx < 64) ? wait_tab[xfer_idx[5:0]] : 0;
  assign bus.mem_ack    = bus.mem_req && (force_ack || (wait_cnt >= cur_wait));
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.alu_result = alu_f(bus.alu_op, acc, bus.alu_operand);

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wait_cnt <= 0; xfer_idx <= 0; total_waits <= 0;
      n_alu <= 0; alu_viol <= 0; stab_viol <= 0; hold_pend <= 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (bus.mem_ack) begin
          wait_cnt <= 0;
          xfer_idx <= xfer_idx + 1;
          if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end else begin
          wait_cnt    <= wait_cnt + 1;
          total_waits <= total_waits + 1;
        end
      end
      if (hold_pend && (!bus.mem_req || bus.mem_addr !== hold_addr ||
                        bus.mem_we !== hold_we || bus.mem_wdata !== hold_wdata))
        stab_viol <= stab_viol + 1;
      hold_pend  <= bus.mem_req && !bus.mem_ack;
      hold_addr  <= bus.mem_addr;
      hold_we    <= bus.mem_we;
      hold_wdata <= bus.mem_wdata;
      if (bus.alu_en) n_alu <= n_alu + 1;
      else if (bus.alu_op != 4'h0 || bus.alu_operand != 8'h00) alu_viol <= alu_viol + 1;
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < 64; i++) wait_tab[i] = 0;
  endtask

  task automatic init_dut();
    rst_n = 1'b0; start = 1'b0; force_ack = 1'b0; tb_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; tb_clr = 1'b0;
  endtask

  // Pulse start, then count busy cycles until halted (bounded).
  task automatic run_prog(output int cyc, output bit timed_out);
    cyc = 0; timed_out = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (halted) begin timed_out = 1'b0; break; end
      if (busy) cyc++;
      @(negedge clk);
    end
  endtask

  // Instruction-level interpreter over mm[].
  task automatic model_run(output logic [7:0] acc_o, output logic [7:0] pc_o,
                           output logic ill_o, output int cyc_o, output int alu_o);
    logic [7:0] p, a;
    logic [3:0] op;
    p = 8'h00; acc_o = 8'h00; ill_o = 1'b0; cyc_o = 0; alu_o = 0;
    for (int s = 0; s < 200; s++) begin
      op = mm[p][3:0];
      p  = p + 8'h01;
      if (op == 4'hF) begin cyc_o += 1; break; end
      if (op >= 4'hB) begin cyc_o += 1; ill_o = 1'b1; break; end
      a = mm[p];
      p = p + 8'h01;
      if (op == 4'hA) begin p = a; cyc_o += 2; end
      else if (op == 4'h9) begin mm[a] = acc_o; cyc_o += 3; end
      else if (op == 4'h8) begin acc_o = mm[a]; cyc_o += 3; end
      else begin acc_o = alu_f(op, acc_o, mm[a]); cyc_o += 4; alu_o++; end
    end
    pc_o = p;
  endtask

  task automatic test_reset();
    clear_env();
    init_dut();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h want 00", acc); end
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    n_tests++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %b want 0", bus.alu_en); end
  endtask

  task automatic test_lda_add_sta();
    int cyc; bit to;
    clear_env();
    prog[0] = 8'h08; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h11;
    prog[4] = 8'h09; prog[5] = 8'h12; prog[6] = 8'h0F;
    prog[8'h10] = 8'h05; prog[8'h11] = 8'h03;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL las_timeout: got %b want 0", to); end
    n_tests++; if (cyc !== 11) begin n_fail++; $display("FAIL las_cycles: got %0d want 11", cyc); end
    n_tests++; if (acc !== 8'h08) begin n_fail++; $display("FAIL las_acc: got %h want 08", acc); end
    n_tests++; if (mem[8'h12] !== 8'h08) begin n_fail++; $display("FAIL las_mem12: got %h want 08", mem[8'h12]); end
    n_tests++; if (pc !== 8'h07) begin n_fail++; $display("FAIL las_pc: got %h want 07", pc); end
    n_tests++; if (n_alu !== 1) begin n_fail++; $display("FAIL las_alu_pulses: got %0d want 1", n_alu); end
    n_tests++; if (alu_viol !== 0) begin n_fail++; $display("FAIL las_alu_idle: got %0d want 0", alu_viol); end
  endtask

  task automatic test_sub_wrap();
    int cyc; bit to;
    clear_env();
    prog[0] = 8'h01; prog[1] = 8'h20; prog[2] = 8'h0F; prog[8'h20] = 8'h01;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (acc !== 8'hFF) begin n_fail++; $display("FAIL sub_acc: got %h want ff", acc); end
    n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL sub_illegal: got %b want 0", illegal); end
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL sub_cycles: got %0d want 5", cyc); end
  endtask

  task automatic test_jmp();
    int cyc; bit to;
    clear_env();
    prog[0] = 8'h0A; prog[1] = 8'h40; prog[8'h40] = 8'h0F;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (pc !== 8'h41) begin n_fail++; $display("FAIL jmp_pc: got %h want 41", pc); end
    n_tests++; if (xfer_idx !== 3) begin n_fail++; $display("FAIL jmp_transfers: got %0d want 3", xfer_idx); end
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL jmp_cycles: got %0d want 3", cyc); end
    clear_env();
    prog[0] = 8'h0A; prog[1] = 8'hFF; prog[8'hFF] = 8'h0F;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL jmp_wrap_pc: got %h want 00", pc); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL jmp_wrap_halted: got %b want 1", halted); end
  endtask

  task automatic test_illegal();
    int cyc; bit to;
    clear_env();
    prog[0] = 8'h3C;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL ill_cycles: got %0d want 1", cyc); end
    n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", illegal); end
    n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL ill_acc: got %h want 00", acc); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_absorb_halted: got %b want 1", halted); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ill_absorb_busy: got %b want 0", busy); end
    n_tests++; if (pc !== 8'h01) begin n_fail++; $display("FAIL ill_absorb_pc: got %h want 01", pc); end
    n_tests++; if (xfer_idx !== 1) begin n_fail++; $display("FAIL ill_absorb_xfers: got %0d want 1", xfer_idx); end
  endtask

  task automatic test_read_wait();
    int cyc; bit to;
    clear_env();
    prog[0] = 8'h00; prog[1] = 8'h10; prog[2] = 8'h0F; prog[8'h10] = 8'h07;
    wait_tab[2] = 3;
    init_dut();
    run_prog(cyc, to);
    n_tests++; if (cyc !== 8) begin n_fail++; $display("FAIL wait_cycles: got %0d want 8", cyc); end
    n_tests++; if (total_waits !== 3) begin n_fail++; $display("FAIL wait_count: got %0d want 3", total_waits); end
    n_tests++; if (stab_viol !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d want 0", stab_viol); end
    n_tests++; if (n_alu !== 1) begin n_fail++; $display("FAIL wait_alu_pulses: got %0d want 1", n_alu); end
    n_tests++; if (acc !== 8'h07) begin n_fail++; $display("FAIL wait_acc: got %h want 07", acc); end
  endtask

  task automatic test_reset_in_write();
    bit seen;
    clear_env();
    prog[0] = 8'h08; prog[1] = 8'h10; prog[2] = 8'h09; prog[3] = 8'h30; prog[4] = 8'h0F;
    prog[8'h10] = 8'h5A;
    wait_tab[5] = 9;
    init_dut();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_req && bus.mem_we) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstw_write_seen: got %b want 1", seen); end
    n_tests++; if (acc !== 8'h5A) begin n_fail++; $display("FAIL rstw_acc_before: got %h want 5a", acc); end
    force_ack = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    force_ack = 1'b0;
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_req_in_reset: got %b want 0", bus.mem_req); end
    n_tests++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL rstw_alu_in_reset: got %b want 0", bus.alu_en); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: got busy=%b halted=%b want 0 0", busy, halted); end
    n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rstw_pc: got %h want 00", pc); end
    n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL rstw_acc: got %h want 00", acc); end
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_random();
    int cyc, mcyc, malu, n;
    bit to;
    logic [7:0] macc, mpc;
    logic mill;
    for (int t = 0; t < 12; t++) begin
      clear_env();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        prog[2*i]   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 9))};
        prog[2*i+1] = 8'h80 + 8'($urandom_range(0, 15));
      end
      prog[2*n] = {4'($urandom_range(0, 15)), (($urandom_range(0, 3) == 0) ? 4'($urandom_range(11, 14)) : 4'hF)};
      for (int i = 8'h80; i < 8'h90; i++) prog[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) wait_tab[i] = $urandom_range(0, 2);
      for (int i = 0; i < 256; i++) mm[i] = prog[i];
      model_run(macc, mpc, mill, mcyc, malu);
      init_dut();
      run_prog(cyc, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: got %b want 0", t, to); end
      n_tests++; if (acc !== macc) begin n_fail++; $display("FAIL rnd%0d_acc: got %h want %h", t, acc, macc); end
      n_tests++; if (pc !== mpc) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", t, pc, mpc); end
      n_tests++; if (illegal !== mill) begin n_fail++; $display("FAIL rnd%0d_illegal: got %b want %b", t, illegal, mill); end
      n_tests++; if (cyc !== mcyc + total_waits) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want %0d", t, cyc, mcyc + total_waits); end
      n_tests++; if (n_alu !== malu) begin n_fail++; $display("FAIL rnd%0d_alu_pulses: got %0d want %0d", t, n_alu, malu); end
      n_tests++; if (stab_viol !== 0 || alu_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_bus_rules: got stab=%0d alu=%0d want 0 0", t, stab_viol, alu_viol); end
      for (int i = 8'h80; i < 8'h90; i++) begin
        n_tests++; if (mem[i] !== mm[i]) begin n_fail++; $display("FAIL rnd%0d_mem%h: got %h want %h", t, i[7:0], mem[i], mm[i]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lda_add_sta();
    test_sub_wrap();
    test_jmp();
    test_illegal();
    test_read_wait();
    test_reset_in_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
